// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers and width limits used by the Gray counter and converter blocks.
// Helpers run on a fixed 32-bit word, so narrower values are zero-extended before the call.
package gray_pkg;

  localparam int GRAY_W_MIN = 2;
  localparam int GRAY_W_MAX = 32;

  typedef logic [GRAY_W_MAX-1:0] gword_t;

  function automatic bit gray_width_ok(input int w);
    return (w >= GRAY_W_MIN) && (w <= GRAY_W_MAX);
  endfunction

  function automatic gword_t bin2gray(input gword_t v);
    return v ^ (v >> 1);
  endfunction

  // Leading zero bits decode to zeros, so a zero-extended narrow code decodes correctly.
  function automatic gword_t gray2bin(input gword_t gv);
    gword_t bv;
    bv[GRAY_W_MAX-1] = gv[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      bv[i] = bv[i+1] ^ gv[i];
    end
    return bv;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter.
// Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] b_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b_o[i] = ^g_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter that holds binary as the arithmetic state and registers the Gray view alongside it.
// tc pulses for one cycle after any count taken from the terminal value (wrap or saturate).
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit WRAP  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic             load_is_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] b,
  output logic             tc
);

  if (!gray_width_ok(WIDTH)) begin : g_bad_width
    $error("gray_updown_counter: WIDTH out of range");
  end

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] load_bin;
  logic             at_term;

  gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
    .g_i (load_val),
    .b_o (load_bin)
  );

  always_comb begin
    at_term = up ? (b_q == ALL_ONES) : (b_q == ZERO);
    b_d     = b_q;
    tc_d    = 1'b0;
    if (load) begin
      b_d = load_is_gray ? load_bin : load_val;
    end else if (en) begin
      tc_d = at_term;
      // Saturating mode parks at the terminal value but still reports the attempted step.
      if (!(at_term && !WRAP)) begin
        b_d = up ? (b_q + ONE) : (b_q - ONE);
      end
    end
    g_d = WIDTH'(bin2gray(gword_t'(b_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_q  <= ZERO;
      g_q  <= ZERO;
      tc_q <= 1'b0;
    end else begin
      b_q  <= b_d;
      g_q  <= g_d;
      tc_q <= tc_d;
    end
  end

  assign g  = g_q;
  assign b  = b_q;
  assign tc = tc_q;

endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 SHALL provide parameter WRAP, default 1: 1 = wrap at the terminal value, 0 = saturate at the terminal value.
REQ-003 SHALL provide port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL provide port en, input, 1 bit: count enable.
REQ-006 SHALL provide port up, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-007 SHALL provide port load, input, 1 bit: parallel load strobe.
REQ-008 SHALL provide port load_is_gray, input, 1 bit: load_val encoding; 1 = Gray, 0 = binary.
REQ-009 SHALL provide port load_val, input, WIDTH bits: value to load.
REQ-010 SHALL provide port g, output, WIDTH bits: registered Gray-coded count.
REQ-011 SHALL provide port b, output, WIDTH bits: registered binary count.
REQ-012 SHALL provide port tc, output, 1 bit: registered terminal-count pulse.

Function
REQ-013 g and b SHALL update on the same edge; at every cycle after reset, g SHALL equal b ^ (b >> 1).
REQ-014 Priority per edge SHALL be: rst > load > en; with none of these asserted, all outputs hold.
REQ-015 Load with load_is_gray=1 SHALL set g = load_val and b = gray-to-binary(load_val), i.e. b[WIDTH-1] = g[WIDTH-1] and b[i] = b[i+1] ^ g[i].
REQ-016 Load with load_is_gray=0 SHALL set b = load_val and g = load_val ^ (load_val >> 1).
REQ-017 Count (en=1, load=0) SHALL set b to b+1 when up=1 and to b-1 when up=0, both modulo 2^WIDTH; g SHALL follow REQ-013.
REQ-018 Terminal value SHALL be all-ones for up=1 and zero for up=0.
REQ-019 WRAP=1 at the terminal value: the counter SHALL wrap (all-ones to 0 when counting up; 0 to all-ones when counting down).
REQ-020 WRAP=0 at the terminal value: the counter SHALL hold its value.
REQ-021 tc SHALL be 1 for exactly the cycle after an edge where a count was performed from the terminal value, in either WRAP mode; otherwise tc = 0.
REQ-022 A load or rst edge SHALL clear tc.
REQ-023 Each count step in WRAP=1 mode, including the wrap step, SHALL change exactly one bit of g.
REQ-024 Latency from input to outputs SHALL be one clock; there SHALL be no combinational path from any input to g, b or tc.
REQ-025 Changing up between consecutive enabled cycles SHALL take effect on the next edge with no dead cycle.

Reset
REQ-026 When rst is sampled high, the next state SHALL be g = 0, b = 0, tc = 0, regardless of en, load or up.
REQ-027 rst asserted mid-count SHALL take effect on the next edge; counting resumes from 0 on the first edge after rst is released with en = 1.

Structure
REQ-028 Shared package gray_pkg SHALL hold the bin2gray and gray2bin functions and the WIDTH legality check constant; it is reused by the existing converter blocks.
REQ-029 SHALL instantiate one sub-module, gray2bin_conv (parametrised WIDTH, combinational), used for the Gray-load path.
REQ-030 The block SHALL keep binary as the arithmetic state and register g from bin2gray of the next binary value.

Verification (WIDTH=4 unless stated)
REQ-031 Reset: rst=1 for 2 cycles with en=1, up=1 -> g=0000, b=0000, tc=0.
REQ-032 Count up from 0, en=1 for 16 edges -> g sequence 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000; one bit changes per step; tc=1 only in the cycle after the 1000->0000 wrap.
REQ-033 Loads: load_is_gray=1, load_val=1101 -> g=1101, b=1001; load_is_gray=0, load_val=0101 -> g=0111, b=0101; load=1 together with en=1 -> load value wins, tc=0.
REQ-034 WRAP=0, load binary 0001, count down for 3 edges -> b = 0000, 0000, 0000; tc=1 after the 2nd and 3rd edges.
REQ-035 Reset mid-count: rst=1 at b=0110 with en=1 -> next edge g=0000, b=0000; after rst falls, the next edge gives b=0001.
REQ-036 Exhaustive WIDTH=8 sweep: load every value in both encodings, then count ±1 -> outputs satisfy REQ-013 and REQ-017 against a reference model in gray_pkg.
